// File: rtl/segre_pkg.sv
// Shared SEGRE core types: address/word sizes, access sizes and
// store buffer entry/state definitions.
package segre_pkg;

    localparam int ADDR_SIZE = 32;
    localparam int WORD_SIZE = 32;

    typedef enum logic [1:0] {
        BYTE,
        HALF,
        WORD
    } memop_data_type_e;

    localparam int SB_DEPTH = 2;

    typedef struct packed {
        logic [ADDR_SIZE-1:0] addr;
        logic [WORD_SIZE-1:0] data;
        memop_data_type_e     memop;
    } sb_entry_t;

    typedef enum logic {
        IDLE,
        FLUSH
    } sb_state_e;

endpackage

// File: rtl/segre_sb_fifo.sv
// Circular entry storage for the store buffer: pointers, occupancy
// count and per-entry valid bits used by the forwarding scan.
module segre_sb_fifo
    import segre_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rsn_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  sb_entry_t             entry_i,
    output sb_entry_t             head_o,
    output sb_entry_t [DEPTH-1:0] entries_o,
    output logic [DEPTH-1:0]      valid_o,
    output logic [PTR_W-1:0]      tail_o,
    output logic [PTR_W:0]        count_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

    sb_entry_t [DEPTH-1:0] mem_q, mem_d;
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [PTR_W:0]        count_q, count_d;
    logic                  push_ok, pop_ok;

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        mem_d   = mem_q;
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop_ok) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_ONE;
        end
        if (push_ok) begin
            mem_d[tail_q]   = entry_i;
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PTR_ONE;
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            mem_q   <= '0;
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_o    = mem_q[head_q];
    assign entries_o = mem_q;
    assign valid_o   = valid_q;
    assign tail_o    = tail_q;
    assign count_o   = count_q;

endmodule

// File: rtl/segre_store_buffer.sv
// MEM-stage store buffer: queues cache-hit stores, drains them on idle
// cache cycles and forwards exact-match data to younger loads.
module segre_store_buffer
    import segre_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rsn_i,
    input  logic                 valid_mem_i,
    input  logic                 store_i,
    input  logic                 load_i,
    input  logic [ADDR_SIZE-1:0] addr_i,
    input  logic [WORD_SIZE-1:0] data_i,
    input  memop_data_type_e     memop_i,
    input  logic                 flush_i,
    input  logic                 dc_wr_ready_i,
    output logic                 dc_wr_o,
    output logic [ADDR_SIZE-1:0] dc_addr_o,
    output logic [WORD_SIZE-1:0] dc_data_o,
    output memop_data_type_e     dc_memop_o,
    output logic                 fwd_hit_o,
    output logic [WORD_SIZE-1:0] fwd_data_o,
    output logic                 draining_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam logic [PTR_W:0] CNT_ONE = (PTR_W+1)'(1);

    sb_state_e             state_q, state_d;
    sb_entry_t             head, new_entry;
    sb_entry_t [DEPTH-1:0] entries;
    logic [DEPTH-1:0]      valid;
    logic [PTR_W-1:0]      tail;
    logic [PTR_W:0]        count;
    logic                  is_load, is_store;
    logic                  push, pop;
    logic                  hit, conflict;
    logic [WORD_SIZE-1:0]  hit_data;

    assign is_load   = valid_mem_i && load_i;
    assign is_store  = valid_mem_i && store_i;
    assign new_entry = '{addr: addr_i, data: data_i, memop: memop_i};

    segre_sb_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk_i     (clk_i),
        .rsn_i     (rsn_i),
        .push_i    (push),
        .pop_i     (pop),
        .entry_i   (new_entry),
        .head_o    (head),
        .entries_o (entries),
        .valid_o   (valid),
        .tail_o    (tail),
        .count_o   (count),
        .full_o    (full_o),
        .empty_o   (empty_o)
    );

    // Youngest entry sits just behind tail; the first word match decides.
    always_comb begin
        logic             found;
        logic [PTR_W-1:0] idx;
        found    = 1'b0;
        idx      = '0;
        hit      = 1'b0;
        conflict = 1'b0;
        hit_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = tail - PTR_W'(k + 1);
            if (is_load && !found && valid[idx] &&
                entries[idx].addr[ADDR_SIZE-1:2] == addr_i[ADDR_SIZE-1:2]) begin
                found = 1'b1;
                if (entries[idx].addr == addr_i &&
                    entries[idx].memop == memop_i) begin
                    hit      = 1'b1;
                    hit_data = entries[idx].data;
                end else begin
                    conflict = 1'b1;
                end
            end
        end
    end

    assign draining_o = (state_q == FLUSH) || conflict || (full_o && is_store);
    assign dc_wr_o    = !empty_o && ((state_q == FLUSH) || !is_load);
    assign pop        = dc_wr_o && dc_wr_ready_i;
    assign push       = is_store && !draining_o;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (conflict || (flush_i && !empty_o)) state_d = FLUSH;
            end
            FLUSH: begin
                if (empty_o || (count == CNT_ONE && pop)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) state_q <= IDLE;
        else        state_q <= state_d;
    end

    assign dc_addr_o  = head.addr;
    assign dc_data_o  = head.data;
    assign dc_memop_o = head.memop;
    assign fwd_hit_o  = hit;
    assign fwd_data_o = hit_data;

endmodule

// File: tb/tb_segre_store_buffer.sv
// Directed bench for segre_store_buffer with a scoreboard of expected
// cache writes and immediate-assertion checks.
module tb_segre_store_buffer;
    import segre_pkg::*;

    logic                 clk_i = 1'b0;
    logic                 rsn_i;
    logic                 valid_mem_i, store_i, load_i, flush_i, dc_wr_ready_i;
    logic [ADDR_SIZE-1:0] addr_i;
    logic [WORD_SIZE-1:0] data_i;
    memop_data_type_e     memop_i;
    logic                 dc_wr_o, fwd_hit_o, draining_o, full_o, empty_o;
    logic [ADDR_SIZE-1:0] dc_addr_o;
    logic [WORD_SIZE-1:0] dc_data_o, fwd_data_o;
    memop_data_type_e     dc_memop_o;

    int n_assert = 0;
    int n_fail   = 0;
    sb_entry_t exp_q[$];

    segre_store_buffer dut (
        .clk_i         (clk_i),
        .rsn_i         (rsn_i),
        .valid_mem_i   (valid_mem_i),
        .store_i       (store_i),
        .load_i        (load_i),
        .addr_i        (addr_i),
        .data_i        (data_i),
        .memop_i       (memop_i),
        .flush_i       (flush_i),
        .dc_wr_ready_i (dc_wr_ready_i),
        .dc_wr_o       (dc_wr_o),
        .dc_addr_o     (dc_addr_o),
        .dc_data_o     (dc_data_o),
        .dc_memop_o    (dc_memop_o),
        .fwd_hit_o     (fwd_hit_o),
        .fwd_data_o    (fwd_data_o),
        .draining_o    (draining_o),
        .full_o        (full_o),
        .empty_o       (empty_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_in(input logic rdy);
        valid_mem_i   = 1'b0;
        store_i       = 1'b0;
        load_i        = 1'b0;
        flush_i       = 1'b0;
        addr_i        = '0;
        data_i        = '0;
        memop_i       = WORD;
        dc_wr_ready_i = rdy;
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d,
                      input memop_data_type_e m, input logic rdy);
        idle_in(rdy);
        valid_mem_i = 1'b1;
        store_i     = 1'b1;
        addr_i      = a;
        data_i      = d;
        memop_i     = m;
    endtask

    task automatic ld(input logic [31:0] a, input memop_data_type_e m,
                      input logic rdy);
        idle_in(rdy);
        valid_mem_i = 1'b1;
        load_i      = 1'b1;
        addr_i      = a;
        memop_i     = m;
    endtask

    task automatic exp_push(input logic [31:0] a, input logic [31:0] d,
                            input memop_data_type_e m);
        exp_q.push_back('{addr: a, data: d, memop: m});
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_wr"},    32'(dc_wr_o), 32'd0);
        chk({tag, "_hit"},   32'(fwd_hit_o), 32'd0);
        chk({tag, "_drain"}, 32'(draining_o), 32'd0);
        chk({tag, "_full"},  32'(full_o), 32'd0);
        chk({tag, "_empty"}, 32'(empty_o), 32'd1);
        chk({tag, "_addr"},  dc_addr_o, 32'd0);
        chk({tag, "_data"},  dc_data_o, 32'd0);
        chk({tag, "_fwd"},   fwd_data_o, 32'd0);
    endtask

    // Every accepted cache write must match the oldest expected store.
    always @(negedge clk_i) begin
        if (rsn_i === 1'b1 && dc_wr_o && dc_wr_ready_i) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_wr", dc_addr_o, 32'hFFFF_FFFF);
            end else begin
                sb_entry_t e;
                e = exp_q.pop_front();
                chk("sb_wr_addr", dc_addr_o, e.addr);
                chk("sb_wr_data", dc_data_o, e.data);
                chk("sb_wr_memop", 32'(dc_memop_o), 32'(e.memop));
            end
        end
    end

    initial begin
        rsn_i = 1'b0;
        idle_in(1'b0);
        #2;
        chk_reset_outs("rst");
        tick();
        tick();
        rsn_i = 1'b1;

        // single store drains on the next cycle
        st(32'h100, 32'hDEADBEEF, WORD, 1'b1);
        exp_push(32'h100, 32'hDEADBEEF, WORD);
        @(negedge clk_i);
        chk("t1_drain", 32'(draining_o), 32'd0);
        chk("t1_wr_pre", 32'(dc_wr_o), 32'd0);
        tick();
        idle_in(1'b1);
        @(negedge clk_i);
        chk("t1_wr", 32'(dc_wr_o), 32'd1);
        chk("t1_addr", dc_addr_o, 32'h100);
        tick();
        @(negedge clk_i);
        chk("t1_empty", 32'(empty_o), 32'd1);
        chk("t1_wr_post", 32'(dc_wr_o), 32'd0);
        tick();

        // fill, stall a third store, push after the first pop
        st(32'h200, 32'hA0A0A0A0, WORD, 1'b0);
        exp_push(32'h200, 32'hA0A0A0A0, WORD);
        tick();
        st(32'h204, 32'hB1B1B1B1, WORD, 1'b0);
        exp_push(32'h204, 32'hB1B1B1B1, WORD);
        tick();
        idle_in(1'b0);
        @(negedge clk_i);
        chk("t2_full", 32'(full_o), 32'd1);
        st(32'h208, 32'hC2C2C2C2, WORD, 1'b0);
        #1;
        chk("t2_drain_full", 32'(draining_o), 32'd1);
        tick();
        st(32'h208, 32'hC2C2C2C2, WORD, 1'b1);
        @(negedge clk_i);
        chk("t2_drain_pop", 32'(draining_o), 32'd1);
        chk("t2_wr_pop", 32'(dc_wr_o), 32'd1);
        tick();
        st(32'h208, 32'hC2C2C2C2, WORD, 1'b0);
        exp_push(32'h208, 32'hC2C2C2C2, WORD);
        @(negedge clk_i);
        chk("t2_drain_free", 32'(draining_o), 32'd0);
        chk("t2_full_free", 32'(full_o), 32'd0);
        tick();
        idle_in(1'b0);
        @(negedge clk_i);
        chk("t2_full_again", 32'(full_o), 32'd1);
        tick();
        idle_in(1'b1);
        tick();
        tick();
        @(negedge clk_i);
        chk("t2_empty", 32'(empty_o), 32'd1);
        tick();

        // youngest exact match forwards
        st(32'h300, 32'h11111111, WORD, 1'b0);
        exp_push(32'h300, 32'h11111111, WORD);
        tick();
        st(32'h300, 32'h22222222, WORD, 1'b0);
        exp_push(32'h300, 32'h22222222, WORD);
        tick();
        ld(32'h300, WORD, 1'b0);
        @(negedge clk_i);
        chk("t3_hit", 32'(fwd_hit_o), 32'd1);
        chk("t3_fwd", fwd_data_o, 32'h22222222);
        chk("t3_drain", 32'(draining_o), 32'd0);
        chk("t3_wr_load", 32'(dc_wr_o), 32'd0);
        tick();
        ld(32'h500, WORD, 1'b0);
        @(negedge clk_i);
        chk("t3_miss_hit", 32'(fwd_hit_o), 32'd0);
        chk("t3_miss_drain", 32'(draining_o), 32'd0);
        tick();
        idle_in(1'b1);
        tick();
        tick();
        @(negedge clk_i);
        chk("t3_empty", 32'(empty_o), 32'd1);
        tick();

        // partial overlap forces a flush
        st(32'h400, 32'hCAFEF00D, WORD, 1'b0);
        exp_push(32'h400, 32'hCAFEF00D, WORD);
        tick();
        ld(32'h401, BYTE, 1'b0);
        @(negedge clk_i);
        chk("t4_hit", 32'(fwd_hit_o), 32'd0);
        chk("t4_conflict", 32'(draining_o), 32'd1);
        chk("t4_wr_idle", 32'(dc_wr_o), 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("t4_hold_drain", 32'(draining_o), 32'd1);
            chk("t4_hold_wr", 32'(dc_wr_o), 32'd1);
            tick();
        end
        ld(32'h401, BYTE, 1'b1);
        @(negedge clk_i);
        chk("t4_pop_drain", 32'(draining_o), 32'd1);
        tick();
        ld(32'h401, BYTE, 1'b0);
        @(negedge clk_i);
        chk("t4_release", 32'(draining_o), 32'd0);
        chk("t4_empty", 32'(empty_o), 32'd1);
        tick();

        // flush pulse with two entries
        st(32'h600, 32'h00000001, WORD, 1'b0);
        exp_push(32'h600, 32'h00000001, WORD);
        tick();
        st(32'h604, 32'h00000002, HALF, 1'b0);
        exp_push(32'h604, 32'h00000002, HALF);
        tick();
        idle_in(1'b0);
        flush_i = 1'b1;
        @(negedge clk_i);
        chk("t5_drain_req", 32'(draining_o), 32'd0);
        tick();
        idle_in(1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            chk("t5_drain", 32'(draining_o), 32'd1);
            chk("t5_wr", 32'(dc_wr_o), 32'd1);
            tick();
        end
        @(negedge clk_i);
        chk("t5_idle", 32'(draining_o), 32'd0);
        chk("t5_empty", 32'(empty_o), 32'd1);
        chk("t5_no_wr", 32'(dc_wr_o), 32'd0);
        tick();

        // async reset in the middle of a flush
        st(32'h700, 32'h77777777, WORD, 1'b0);
        exp_push(32'h700, 32'h77777777, WORD);
        tick();
        st(32'h704, 32'h88888888, WORD, 1'b0);
        exp_push(32'h704, 32'h88888888, WORD);
        tick();
        idle_in(1'b0);
        flush_i = 1'b1;
        tick();
        idle_in(1'b0);
        @(negedge clk_i);
        chk("t6_flushing", 32'(draining_o), 32'd1);
        #2;
        rsn_i = 1'b0;
        #1;
        chk_reset_outs("t6_rst");
        exp_q.delete();
        tick();
        idle_in(1'b1);
        rsn_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("t6_no_wr", 32'(dc_wr_o), 32'd0);
            chk("t6_empty", 32'(empty_o), 32'd1);
            tick();
        end

        chk("sb_left", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
